// File: rtl/port_reader.sv
// Egress read engine for one output port: picks the highest-priority queue, walks its
// page chain, fetches each 8-word page plus ECC code, and streams corrected words out.
module port_reader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   q_nonempty,
  output logic         pg_req,
  output logic [2:0]   pg_prior,
  input  logic         pg_vld,
  input  logic [4:0]   pg_sram,
  input  logic [10:0]  pg_addr,
  output logic         pg_free,
  output logic [4:0]   pg_free_sram,
  output logic [10:0]  pg_free_addr,
  output logic [4:0]   sram_sel,
  output logic         rd_en,
  output logic [13:0]  rd_addr,
  input  logic [15:0]  dout,
  output logic         ecc_rd_en,
  input  logic [7:0]   ecc_dout,
  output logic [127:0] dec_data,
  output logic [7:0]   dec_code,
  input  logic [127:0] cr_data,
  input  logic         ecc_uncorr,
  output logic         out_vld,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic         out_sop,
  output logic         out_eop,
  output logic         out_err,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FETCH = 2'd2, EMIT = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [2:0]  prior_q, prior_d;
  logic [4:0]  sram_q, sram_d;
  logic [10:0] addr_q, addr_d;
  logic [3:0]  f_q, f_d;
  logic [2:0]  e_q, e_d;
  logic [8:0]  rem_q, rem_d;
  logic        first_q, first_d;
  logic        err_acc_q, err_acc_d;
  logic [7:0]  code_q;
  logic [15:0] buf_q [8];
  logic        free_q;
  logic [4:0]  free_sram_q;
  logic [10:0] free_addr_q;

  logic [2:0]  hi_prior;
  logic [15:0] word;
  logic [8:0]  hdr_len, rem_cur;
  logic        is_eop, accept, page_end;

  always_comb begin
    hi_prior = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (q_nonempty[i]) hi_prior = 3'(i);
    end
  end

  // The header word carries the packet length; the count is live on word 0 of the first
  // page so a one-word packet can flag eop immediately.
  assign word     = cr_data[{e_q, 4'b0000} +: 16];
  assign hdr_len  = (word[15:7] == 9'd0) ? 9'd1 : word[15:7];
  assign rem_cur  = (first_q && e_q == 3'd0) ? hdr_len : rem_q;
  assign is_eop   = (state_q == EMIT) && (rem_cur == 9'd1);
  assign accept   = (state_q == EMIT) && out_ready;
  assign page_end = accept && ((e_q == 3'd7) || is_eop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prior_q     <= 3'd0;
      sram_q      <= 5'd0;
      addr_q      <= 11'd0;
      f_q         <= 4'd0;
      e_q         <= 3'd0;
      rem_q       <= 9'd0;
      first_q     <= 1'b0;
      err_acc_q   <= 1'b0;
      code_q      <= 8'd0;
      free_q      <= 1'b0;
      free_sram_q <= 5'd0;
      free_addr_q <= 11'd0;
      for (int k = 0; k < 8; k++) buf_q[k] <= 16'd0;
    end else begin
      state_q   <= state_d;
      prior_q   <= prior_d;
      sram_q    <= sram_d;
      addr_q    <= addr_d;
      f_q       <= f_d;
      e_q       <= e_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      err_acc_q <= err_acc_d;
      free_q    <= page_end;
      if (page_end) begin
        free_sram_q <= sram_q;
        free_addr_q <= addr_q;
      end
      // SRAM data lags the read strobe by one cycle.
      if (state_q == FETCH && f_q != 4'd0) buf_q[f_q[2:0] - 3'd1] <= dout;
      if (state_q == FETCH && f_q == 4'd1) code_q <= ecc_dout;
    end
  end

  always_comb begin
    state_d   = state_q;
    prior_d   = prior_q;
    sram_d    = sram_q;
    addr_d    = addr_q;
    f_d       = f_q;
    e_d       = e_q;
    rem_d     = rem_q;
    first_d   = first_q;
    err_acc_d = err_acc_q;
    case (state_q)
      IDLE: begin
        if (q_nonempty != 8'd0) begin
          prior_d = hi_prior;
          first_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (pg_vld) begin
          sram_d  = pg_sram;
          addr_d  = pg_addr;
          f_d     = 4'd0;
          e_d     = 3'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        f_d = f_q + 4'd1;
        if (f_q == 4'd8) begin
          f_d     = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (accept) begin
          rem_d = rem_cur - 9'd1;
          e_d   = e_q + 3'd1;
        end
        if (page_end) begin
          err_acc_d = err_acc_q | ecc_uncorr;
          first_d   = 1'b0;
          if (is_eop) begin
            err_acc_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pg_req       = (state_q == REQ);
    pg_prior     = prior_q;
    sram_sel     = sram_q;
    rd_en        = (state_q == FETCH) && !f_q[3];
    rd_addr      = rd_en ? {addr_q, f_q[2:0]} : 14'd0;
    ecc_rd_en    = (state_q == FETCH) && (f_q == 4'd0);
    dec_code     = code_q;
    dec_data     = '0;
    for (int k = 0; k < 8; k++) dec_data[16*k +: 16] = buf_q[k];
    out_vld      = (state_q == EMIT);
    out_data     = out_vld ? word : 16'd0;
    out_sop      = out_vld && first_q && (e_q == 3'd0);
    out_eop      = is_eop;
    out_err      = is_eop && (err_acc_q | ecc_uncorr);
    pg_free      = free_q;
    pg_free_sram = free_sram_q;
    pg_free_addr = free_addr_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_port_reader.sv
// Bench for port_reader: SRAM/ECC/controller models plus a queue-based scoreboard that
// checks grants, read addresses, streamed words, page frees and timing.
module tb_port_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [7:0]   q_nonempty = 8'd0;
  logic         pg_req;
  logic [2:0]   pg_prior;
  logic         pg_vld;
  logic [4:0]   pg_sram;
  logic [10:0]  pg_addr;
  logic         pg_free;
  logic [4:0]   pg_free_sram;
  logic [10:0]  pg_free_addr;
  logic [4:0]   sram_sel;
  logic         rd_en;
  logic [13:0]  rd_addr;
  logic [15:0]  dout = 16'd0;
  logic         ecc_rd_en;
  logic [7:0]   ecc_dout = 8'd0;
  logic [127:0] dec_data;
  logic [7:0]   dec_code;
  logic [127:0] cr_data;
  logic         ecc_uncorr;
  logic         out_vld;
  logic         out_ready;
  logic [15:0]  out_data;
  logic         out_sop;
  logic         out_eop;
  logic         out_err;
  logic [1:0]   dbg_state;

  port_reader dut (
    .clk(clk), .rst_n(rst_n), .q_nonempty(q_nonempty),
    .pg_req(pg_req), .pg_prior(pg_prior), .pg_vld(pg_vld), .pg_sram(pg_sram), .pg_addr(pg_addr),
    .pg_free(pg_free), .pg_free_sram(pg_free_sram), .pg_free_addr(pg_free_addr),
    .sram_sel(sram_sel), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout),
    .ecc_rd_en(ecc_rd_en), .ecc_dout(ecc_dout), .dec_data(dec_data), .dec_code(dec_code),
    .cr_data(cr_data), .ecc_uncorr(ecc_uncorr),
    .out_vld(out_vld), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment models ----------------
  logic [15:0] mem [int];
  logic [7:0]  ecc_mem [int];
  // Decoder stand-in: data passes through, code 8'hEE marks an uncorrectable page.
  assign cr_data    = dec_data;
  assign ecc_uncorr = (dec_code == 8'hEE);

  always @(posedge clk) begin
    if (rd_en) dout <= mem.exists(int'({sram_sel, rd_addr})) ? mem[int'({sram_sel, rd_addr})] : 16'hDEAD;
    if (ecc_rd_en) ecc_dout <= ecc_mem.exists(int'({sram_sel, rd_addr[13:3]})) ?
                               ecc_mem[int'({sram_sel, rd_addr[13:3]})] : 8'h00;
  end

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];    // {page_last, err, eop, sop, data}
  logic [15:0] free_q[$];   // {sram, addr}
  logic [19:0] grant_q[$];  // {first_page, prior, sram, addr}
  logic [18:0] rd_q[$];     // {sram, addr, word}
  int checks = 0;
  int errors = 0;
  int granted = 0;
  int ecc_cnt = 0;
  int grant_cyc = -100;
  int free_due = -100;
  int rdy_mode = 0;         // 0 always ready, 1 pattern 1-0-0-1, 2 never ready

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input int id, input int prior, input int len, input int bad);
    int eff, npg, i;
    logic [15:0] d;
    logic [4:0]  s;
    logic [10:0] a;
    logic        eop, last;
    eff = (len == 0) ? 1 : len;
    npg = (eff + 7) / 8;
    for (int p = 0; p < npg; p++) begin
      s = 5'((id * 5 + p) % 32);
      a = 11'(64 + id * 4 + p);
      ecc_mem[int'({s, a})] = (p == bad) ? 8'hEE : 8'h3C;
      grant_q.push_back({(p == 0), 3'(prior), s, a});
      free_q.push_back({s, a});
      for (int w = 0; w < 8; w++) begin
        i = p * 8 + w;
        d = (i == 0) ? {9'(len), 7'(id)} : {8'(id), 8'(i)};
        mem[int'({s, a, 3'(w)})] = d;
        if (i < eff) begin
          eop  = (i == eff - 1);
          last = eop || (w == 7);
          exp_q.push_back({last, eop && (bad >= 0) && (bad < npg), eop, (i == 0), d});
        end
      end
    end
  endtask

  task automatic wait_done(input string nm);
    bit done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (free_q.size() == 0) && (grant_q.size() == 0) &&
             (dbg_state == 2'd0) && !pg_free;
    end
    chk({nm, "_completion"}, 32'(done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- controller model ----------------
  initial begin
    logic [19:0] g;
    logic [7:0]  m;
    pg_vld = 1'b0; pg_sram = 5'd0; pg_addr = 11'd0;
    forever begin
      @(negedge clk);
      m = 8'd0;
      foreach (grant_q[j]) if (grant_q[j][19]) m[grant_q[j][18:16]] = 1'b1;
      q_nonempty = m;
      if (rst_n && pg_req) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_pg_req", 32'd1, 32'd0);
        end else begin
          g = grant_q.pop_front();
          chk("pg_prior", 32'(pg_prior), 32'(g[18:16]));
          @(posedge clk); #1;
          pg_vld = 1'b1; pg_sram = g[15:11]; pg_addr = g[10:0];
          for (int k = 0; k < 8; k++) rd_q.push_back({g[15:0], 3'(k)});
          granted++;
          @(posedge clk); #1;
          pg_vld = 1'b0;
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? pat[cyc % 4] : 1'b0;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        stall_prev, vld_prev;
    logic [18:0] prev_word;
    logic [19:0] e;
    logic [18:0] r;
    logic [15:0] f;
    stall_prev = 1'b0; vld_prev = 1'b0; prev_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        vld_prev   = 1'b0;
      end else begin
        if (pg_vld) grant_cyc = cyc;
        if (out_vld && !vld_prev) chk("first_vld_latency", 32'(cyc - grant_cyc), 32'd10);
        if (stall_prev) begin
          chk("stall_vld_held", 32'(out_vld), 32'd1);
          chk("stall_word_held", 32'({out_err, out_eop, out_sop, out_data}), 32'(prev_word));
        end
        if (rd_en) begin
          if (rd_q.size() == 0) chk("unexpected_rd_en", 32'd1, 32'd0);
          else begin
            r = rd_q.pop_front();
            chk("rd_sram_addr", 32'({sram_sel, rd_addr}), 32'(r));
          end
          chk("ecc_rd_on_word0", 32'(ecc_rd_en), 32'(rd_addr[2:0] == 3'd0));
        end
        if (ecc_rd_en) ecc_cnt++;
        if (pg_free) begin
          chk("pg_free_timing", 32'(cyc), 32'(free_due));
          if (free_q.size() == 0) chk("unexpected_pg_free", 32'd1, 32'd0);
          else begin
            f = free_q.pop_front();
            chk("pg_free_page", 32'({pg_free_sram, pg_free_addr}), 32'(f));
          end
        end
        if (out_vld && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("out_word{err,eop,sop,data}", 32'({out_err, out_eop, out_sop, out_data}), 32'(e[18:0]));
            if (e[19]) free_due = cyc + 1;
          end
        end
        stall_prev = out_vld && !out_ready;
        prev_word  = {out_err, out_eop, out_sop, out_data};
        vld_prev   = out_vld;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_outs", 32'({pg_req, pg_prior, pg_free, rd_en, ecc_rd_en, out_vld, out_sop, out_eop, out_err}), 32'd0);
    chk("rst_addr", 32'({sram_sel, rd_addr, pg_free_sram, pg_free_addr}), 32'd0);
    chk("rst_dec", 32'(|dec_data) | 32'(dec_code), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    load_pkt(1, 3, 5, -1);            // single page, len 5
    wait_done("single_len5");

    load_pkt(2, 7, 3, -1);            // served first: prior 7
    load_pkt(3, 4, 8, -1);            // then prior 4, exactly one full page
    wait_done("prio_7_then_4");

    load_pkt(4, 1, 20, -1);           // three pages 8/8/4
    wait_done("len20");

    rdy_mode = 1;
    load_pkt(5, 1, 20, -1);
    wait_done("len20_backpressure");
    rdy_mode = 0;

    load_pkt(6, 5, 18, 1);            // page 2 uncorrectable
    wait_done("uncorr_page2");
    load_pkt(7, 5, 2, -1);            // error must not leak into next packet
    wait_done("after_uncorr");

    load_pkt(8, 0, 0, -1);            // header len 0 behaves as 1
    wait_done("len0");

    // Reset mid-EMIT of page 1 with the output stalled.
    rdy_mode = 2;
    load_pkt(9, 2, 12, -1);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = out_vld;
    end
    chk("reset_test_reached_emit", 32'(seen), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(dbg_state), 32'd0);
    chk("midrst_outs", 32'({pg_req, pg_free, rd_en, ecc_rd_en, out_vld, out_sop, out_eop, out_err}), 32'd0);
    chk("midrst_data", 32'(out_data) | 32'(|dec_data), 32'd0);
    exp_q.delete(); free_q.delete(); grant_q.delete(); rd_q.delete();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_pkt(10, 6, 3, -1);
    wait_done("after_reset");

    chk("ecc_reads_per_page", 32'(ecc_cnt), 32'(granted));
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
